// File: rtl/rvv_backend_pkg.sv
// Shared definitions for the scalar-to-vector issue path: the packed
// instruction payload, the default issue width and the prefix-accept rule
// that decides how many lanes the backend takes in one cycle.
package rvv_backend_pkg;

  localparam int DEF_ISSUE_LANES = 2;
  localparam int RVVCMD_W        = 64;

  // Widest lane vector the prefix-accept helper handles.
  localparam int MAX_LANES       = 8;

  typedef logic [RVVCMD_W-1:0] RVVCmd;

  // Number of lanes that transfer: counts from lane 0 upward while each lane
  // is both valid and ready, and stops at the first lane that is not.
  // A ready seen above that first gap never counts.
  function automatic logic [3:0] prefix_pop(input logic [MAX_LANES-1:0] valid,
                                            input logic [MAX_LANES-1:0] ready,
                                            input int                   lanes);
    logic [3:0] k;
    logic       run;
    k   = '0;
    run = 1'b1;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (run && (i < lanes) && valid[i] && ready[i]) k = k + 4'd1;
      else run = 1'b0;
    end
    return k;
  endfunction

endpackage

// File: rtl/rvv_inst_issue_buf.sv
// Instruction issue buffer in front of the vector backend. Takes one decoded
// instruction per cycle from the scalar core and offers the oldest
// ISSUE_LANES entries in order. A trap flush drops everything pending.
module rvv_inst_issue_buf
  import rvv_backend_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ISSUE_LANES = DEF_ISSUE_LANES,
  parameter int INST_W      = RVVCMD_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                inst_valid_s2b,
  input  logic [INST_W-1:0]                   inst_s2b,
  output logic                                inst_ready_b2s,
  input  logic                                flush,
  output logic [ISSUE_LANES-1:0]              insts_valid_rvs2cq,
  output logic [ISSUE_LANES-1:0][INST_W-1:0]  insts_rvs2cq,
  input  logic [ISSUE_LANES-1:0]              insts_ready_cq2rvs,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output logic                                empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INST_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [AW-1:0]     lane_idx [ISSUE_LANES];
  logic              push;
  logic [3:0]        pop_k;

  // The extra wrap bit makes the pointer difference the occupancy directly.
  assign count = CNT_W'(wr_ptr - rd_ptr);
  assign empty = (count == '0);

  // Acceptance looks at current occupancy only; a pop this cycle does not
  // free a slot for a push in the same cycle.
  assign inst_ready_b2s = rst_n & ~flush & (count < CNT_W'(DEPTH));
  assign push           = inst_valid_s2b & inst_ready_b2s;

  for (genvar i = 0; i < ISSUE_LANES; i++) begin : g_lane
    // Index arithmetic truncates to AW bits so lanes wrap into mem[0..].
    assign lane_idx[i]           = rd_ptr[AW-1:0] + AW'(i);
    assign insts_valid_rvs2cq[i] = (count > CNT_W'(i)) & ~flush;
    assign insts_rvs2cq[i]       = mem[lane_idx[i]];
  end

  assign pop_k = prefix_pop(MAX_LANES'(insts_valid_rvs2cq),
                            MAX_LANES'(insts_ready_cq2rvs),
                            ISSUE_LANES);

  // Payload storage, written at the tail; intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= inst_s2b;
  end

  // Pointer update: flush returns both pointers to zero, otherwise advance by
  // the pushed and popped counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_k);
      wr_ptr <= wr_ptr + PTR_W'(push);
    end
  end

endmodule

// File: tb/tb_rvv_inst_issue_buf.sv
// Bench for rvv_inst_issue_buf: directed scenarios plus a randomized stream,
// all checked against a queue-based reference of the buffer contents.
module tb_rvv_inst_issue_buf;
  import rvv_backend_pkg::*;

  localparam int DEPTH = 8;
  localparam int LANES = 2;
  localparam int IW    = 64;

  logic                        clk;
  logic                        rst_n;
  logic                        inst_valid_s2b;
  logic [IW-1:0]               inst_s2b;
  logic                        inst_ready_b2s;
  logic                        flush;
  logic [LANES-1:0]            insts_valid_rvs2cq;
  logic [LANES-1:0][IW-1:0]    insts_rvs2cq;
  logic [LANES-1:0]            insts_ready_cq2rvs;
  logic [$clog2(DEPTH+1)-1:0]  count;
  logic                        empty;

  rvv_inst_issue_buf #(.DEPTH(DEPTH), .ISSUE_LANES(LANES), .INST_W(IW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .inst_valid_s2b     (inst_valid_s2b),
    .inst_s2b           (inst_s2b),
    .inst_ready_b2s     (inst_ready_b2s),
    .flush              (flush),
    .insts_valid_rvs2cq (insts_valid_rvs2cq),
    .insts_rvs2cq       (insts_rvs2cq),
    .insts_ready_cq2rvs (insts_ready_cq2rvs),
    .count              (count),
    .empty              (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_issued = 0;
  RVVCmd q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic RVVCmd rnd_cmd();
    return {$urandom, $urandom};
  endfunction

  // One clock cycle, starting and ending at a falling edge. Drives inputs,
  // checks every output against the reference queue, then advances it.
  task automatic step(input logic v, input RVVCmd d, input logic fl, input logic [LANES-1:0] rdy);
    int                 sz;
    logic               mready;
    logic [MAX_LANES-1:0] mv;
    logic [3:0]         k;
    inst_valid_s2b     = v;
    inst_s2b           = d;
    flush              = fl;
    insts_ready_cq2rvs = rdy;
    #1;
    sz     = q.size();
    mready = !fl && (sz < DEPTH);
    mv     = '0;
    chk("inst_ready", inst_ready_b2s, mready);
    chk("count", count, sz);
    chk("empty", empty, sz == 0);
    for (int i = 0; i < LANES; i++) begin
      mv[i] = (sz > i) && !fl;
      chk($sformatf("lane%0d_valid", i), insts_valid_rvs2cq[i], mv[i]);
      if (mv[i]) chk($sformatf("lane%0d_data", i), insts_rvs2cq[i], q[i]);
    end
    k = prefix_pop(mv, MAX_LANES'(rdy), LANES);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      for (int i = 0; i < int'(k); i++) begin
        void'(q.pop_front());
        n_issued++;
      end
      if (v && mready) q.push_back(d);
    end
    @(negedge clk);
  endtask

  RVVCmd a, b, c, held;

  initial begin
    rst_n = 1'b0;
    inst_valid_s2b = 1'b0;
    inst_s2b = '0;
    flush = 1'b0;
    insts_ready_cq2rvs = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_valid", insts_valid_rvs2cq, 0);
    chk("rst_ready", inst_ready_b2s, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // A, B present before the backend opens, then both issue together.
    a = rnd_cmd(); b = rnd_cmd(); c = rnd_cmd();
    step(1, a, 0, 2'b00);
    chk("a_visible", insts_rvs2cq[0], a);
    step(1, b, 0, 2'b00);
    step(1, c, 0, 2'b11);
    chk("c_left", count, 1);
    chk("c_lane0", insts_rvs2cq[0], c);
    step(0, '0, 0, 2'b11);
    chk("abc_count", count, 0);
    chk("abc_empty", empty, 1);

    // Fill to the brim, then one single-lane pop while offering a push.
    for (int i = 0; i < DEPTH; i++) step(1, rnd_cmd(), 0, 2'b00);
    chk("full_count", count, DEPTH);
    chk("full_ready", inst_ready_b2s, 0);
    step(1, rnd_cmd(), 0, 2'b01);
    chk("pop1_count", count, DEPTH - 1);
    chk("pop1_ready", inst_ready_b2s, 1);

    // Ready only on the upper lane: nothing moves.
    held = q[0];
    step(0, '0, 0, 2'b10);
    chk("gap_count", count, DEPTH - 1);
    chk("gap_lane0", insts_rvs2cq[0], held);

    // Drain, refill three, then flush while offering a push.
    while (q.size() > 0) step(0, '0, 0, 2'b11);
    for (int i = 0; i < 3; i++) step(1, rnd_cmd(), 0, 2'b00);
    inst_valid_s2b = 1'b1; inst_s2b = rnd_cmd(); flush = 1'b1; insts_ready_cq2rvs = 2'b11;
    #1;
    chk("flush_valid", insts_valid_rvs2cq, 0);
    chk("flush_ready", inst_ready_b2s, 0);
    step(1, inst_s2b, 1, 2'b11);
    chk("flush_count", count, 0);
    step(0, '0, 0, 2'b11);

    // Randomized stream crossing the pointer wrap several times.
    begin
      int pushed;
      pushed = 0;
      for (int cyc = 0; cyc < 400 && (pushed < 20 || q.size() > 0); cyc++) begin
        logic v;
        v = (pushed < 20) && ($urandom_range(0, 3) != 0);
        if (v && q.size() < DEPTH) pushed++;
        step(v, rnd_cmd(), 0, LANES'($urandom_range(0, 3)));
      end
      chk("stream_drained", count, 0);
    end

    // Asynchronous reset with five entries held.
    for (int i = 0; i < 5; i++) step(1, rnd_cmd(), 0, 2'b00);
    chk("pre_rst_count", count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_valid", insts_valid_rvs2cq, 0);
    chk("arst_ready", inst_ready_b2s, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, '0, 0, 2'b11);
    chk("post_rst_empty", empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
